instr_assembler: RTL and testbench

//  Packs decoded MIPS fields (format, opcode, rs/rt/rd, shamt, funct, imm, address) into 32-bit words.

---
 rtl/instr_fmt_pkg.sv | 24 ++
 rtl/instr_word_fifo.sv | 59 +++++
 rtl/instr_assembler.sv | 127 ++++++++++++
 tb/tb_instr_assembler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fmt_pkg.sv
// MIPS instruction format codes and field bit positions.
// Shared between the assembler and the decode-stage field splitters.
package instr_fmt_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int ADDR_LSB  = 0;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_result_t;

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous first-word-fall-through FIFO; the head reads straight from the array.
// When empty, the output keeps presenting the most recently popped word.
module instr_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_occ;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;

  assign full      = (r_occ == (AW+1)'(DEPTH));
  assign empty     = (r_occ == '0);
  assign occupancy = r_occ;
  assign w_push    = push && !full;
  assign w_pop     = pop && !empty;
  assign rdata     = empty ? r_last : r_mem[r_rd_ptr];

  // Storage is not reset: an empty FIFO never exposes the array, only r_last.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/instr_assembler.sv
// Packs decoded MIPS fields into 32-bit words, rejecting illegal formats and
// out-of-range immediates, and queues legal words behind a valid/ready FIFO.
module instr_assembler
  import instr_fmt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_format,
  input  logic [5:0]       in_opcode,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_imm,
  input  logic             in_imm_sign,
  input  logic [25:0]      in_address,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      word_count
);

  function automatic enc_result_t encode(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [31:0] imm,
    input logic        sgn,
    input logic [25:0] addr
  );
    enc_result_t res;
    res.ok   = 1'b1;
    res.word = 32'(op) << OP_LSB;
    case (fmt)
      FMT_R: res.word = res.word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                      | (32'(rd) << RD_LSB) | (32'(sh) << SHAMT_LSB)
                      | (32'(fn) << FUNCT_LSB);
      FMT_I: begin
        res.word = res.word | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB)
                 | (32'(imm[15:0]) << IMM_LSB);
        // Signed: bits 31:15 must be a pure sign extension. Unsigned: upper half zero.
        res.ok = sgn ? ((&imm[31:15]) || !(|imm[31:15])) : !(|imm[31:16]);
      end
      FMT_J: res.word = res.word | (32'(addr) << ADDR_LSB);
      default: begin
        res.ok   = 1'b0;
        res.word = '0;
      end
    endcase
    return res;
  endfunction

  enc_result_t              w_enc;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(DEPTH):0]   w_occupancy;
  logic                     r_err_pulse;
  logic [ERR_W-1:0]         r_err_count;
  logic [15:0]              r_word_count;

  assign w_enc = encode(in_format, in_opcode, in_rs, in_rt, in_rd, in_shamt,
                        in_funct, in_imm, in_imm_sign, in_address);

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_enc.ok;
  assign w_pop     = out_valid && out_ready;

  instr_word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .wdata     (w_enc.word),
    .pop       (w_pop),
    .rdata     (out_instr),
    .full      (w_full),
    .empty     (w_empty),
    .occupancy (w_occupancy)
  );

  // Rejected requests still complete the handshake; they only bump the error state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
      r_word_count <= '0;
    end else begin
      r_err_pulse <= w_accept && !w_enc.ok;
      if (w_accept && !w_enc.ok && (r_err_count != '1)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
      if (w_push) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (int'(w_occupancy) <= DEPTH);
    end
  end

  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench for instr_assembler: directed vector table, hand-built FIFO/reset sequences
// and random traffic, all checked against a queue-based reference model.
module tb_instr_assembler;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_format;
  logic [5:0]       in_opcode;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [4:0]       in_shamt;
  logic [5:0]       in_funct;
  logic [31:0]      in_imm;
  logic             in_imm_sign;
  logic [25:0]      in_address;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      word_count;

  always #5 clock = ~clock;

  instr_assembler #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_format   (in_format),
    .in_opcode   (in_opcode),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_funct    (in_funct),
    .in_imm      (in_imm),
    .in_imm_sign (in_imm_sign),
    .in_address  (in_address),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .word_count  (word_count)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic        sgn;
    logic [25:0] addr;
    logic        ok;
    logic [31:0] word;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] q[$];
  logic [31:0] m_last;
  bit          m_err;
  int          m_errc;
  logic [15:0] m_wc;

  logic [31:0] bnd [8] = '{32'h0000_7FFF, 32'h0000_8000, 32'h0000_FFFF, 32'h0001_0000,
                           32'hFFFF_8000, 32'hFFFF_7FFF, 32'hFFFF_FFFF, 32'h8000_0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference encoding from field weights and integer range limits.
  function automatic void model_enc(output bit ok, output logic [31:0] w);
    longint v;
    v  = longint'(in_opcode) * 67108864;
    ok = 1'b1;
    case (in_format)
      2'd0: v = v + longint'(in_rs) * 2097152 + longint'(in_rt) * 65536
              + longint'(in_rd) * 2048 + longint'(in_shamt) * 64 + longint'(in_funct);
      2'd1: begin
        v = v + longint'(in_rs) * 2097152 + longint'(in_rt) * 65536 + (longint'(in_imm) % 65536);
        if (in_imm_sign) ok = ($signed(in_imm) >= -32768) && ($signed(in_imm) <= 32767);
        else             ok = (in_imm <= 32'd65535);
      end
      2'd2: v = v + longint'(in_address);
      default: begin
        ok = 1'b0;
        v  = 0;
      end
    endcase
    w = v[31:0];
  endfunction

  task automatic check_all();
    chk("in_ready",   32'(in_ready),   32'(q.size() < DEPTH));
    chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
    chk("out_instr",  out_instr,       (q.size() != 0) ? q[0] : m_last);
    chk("err_pulse",  32'(err_pulse),  32'(m_err));
    chk("err_count",  32'(err_count),  32'(m_errc));
    chk("word_count", 32'(word_count), 32'(m_wc));
    chk("occupancy",  32'(dut.w_occupancy), 32'(q.size()));
  endtask

  // One clock: model decides from pre-edge inputs, DUT is checked on the next falling edge.
  task automatic tick(output bit acc);
    bit          ok;
    bit          pop;
    logic [31:0] w;
    int          sz;
    model_enc(ok, w);
    sz  = q.size();
    acc = in_valid && (sz < DEPTH) && !reset;
    pop = out_ready && (sz > 0);
    @(posedge clock);
    if (reset) begin
      q.delete();
      m_last = '0;
      m_err  = 1'b0;
      m_errc = 0;
      m_wc   = '0;
    end else begin
      if (pop) m_last = q.pop_front();
      if (acc && ok) begin
        q.push_back(w);
        m_wc = m_wc + 16'd1;
      end
      m_err = acc && !ok;
      if (acc && !ok && m_errc != 255) m_errc++;
    end
    @(negedge clock);
    check_all();
  endtask

  task automatic set_fields(input vec_t v);
    in_format   = v.fmt;
    in_opcode   = v.op;
    in_rs       = v.rs;
    in_rt       = v.rt;
    in_rd       = v.rd;
    in_shamt    = v.sh;
    in_funct    = v.fn;
    in_imm      = v.imm;
    in_imm_sign = v.sgn;
    in_address  = v.addr;
  endtask

  task automatic set_j(input logic [25:0] addr);
    in_format  = 2'd2;
    in_opcode  = 6'd2;
    in_address = addr;
  endtask

  task automatic rand_fields();
    in_format   = 2'($urandom_range(0, 3));
    in_opcode   = 6'($urandom);
    in_rs       = 5'($urandom);
    in_rt       = 5'($urandom);
    in_rd       = 5'($urandom);
    in_shamt    = 5'($urandom);
    in_funct    = 6'($urandom);
    in_imm_sign = 1'($urandom);
    in_address  = 26'($urandom);
    case ($urandom_range(0, 3))
      0:       in_imm = $urandom;
      1:       in_imm = 32'($urandom_range(0, 65535));
      2:       in_imm = 32'($urandom_range(0, 65535)) - 32'd32768;
      default: in_imm = bnd[$urandom_range(0, 7)];
    endcase
  endtask

  function automatic vec_t mk(input logic [1:0] fmt, input logic [5:0] op,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh,
                              input logic [5:0] fn, input logic [31:0] imm,
                              input logic sgn, input logic [25:0] addr,
                              input logic ok, input logic [31:0] word);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh; v.fn = fn;
    v.imm = imm; v.sgn = sgn; v.addr = addr; v.ok = ok; v.word = word;
    return v;
  endfunction

  initial begin
    vec_t        vecs [15];
    vec_t        v;
    bit          acc;
    bit          done5;
    int          n_ok;
    int          n_bad;
    logic [31:0] got[$];

    vecs[0]  = mk(2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 32'h0,         1'b0, 26'h0,       1'b1, 32'h0022_1820);
    vecs[1]  = mk(2'd1, 6'h08, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 32'hFFFF_FFFF, 1'b1, 26'h0,       1'b1, 32'h2022_FFFF);
    vecs[2]  = mk(2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h0,         1'b0, 26'h40,      1'b1, 32'h0800_0040);
    vecs[3]  = mk(2'd1, 6'h0D, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00, 32'h0001_0000, 1'b0, 26'h0,       1'b0, 32'h0);
    vecs[4]  = mk(2'd3, 6'h08, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 32'h0,         1'b0, 26'h40,      1'b0, 32'h0);
    vecs[5]  = mk(2'd1, 6'h08, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h0000_7FFF, 1'b1, 26'h0,       1'b1, 32'h2000_7FFF);
    vecs[6]  = mk(2'd1, 6'h08, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h0000_8000, 1'b1, 26'h0,       1'b0, 32'h0);
    vecs[7]  = mk(2'd1, 6'h08, 5'd3,  5'd4,  5'd0,  5'd0,  6'h00, 32'hFFFF_8000, 1'b1, 26'h0,       1'b1, 32'h2064_8000);
    vecs[8]  = mk(2'd1, 6'h08, 5'd3,  5'd4,  5'd0,  5'd0,  6'h00, 32'hFFFF_7FFF, 1'b1, 26'h0,       1'b0, 32'h0);
    vecs[9]  = mk(2'd1, 6'h0D, 5'd2,  5'd5,  5'd0,  5'd0,  6'h00, 32'h0000_FFFF, 1'b0, 26'h0,       1'b1, 32'h3445_FFFF);
    vecs[10] = mk(2'd1, 6'h0D, 5'd2,  5'd5,  5'd0,  5'd0,  6'h00, 32'hFFFF_FFFF, 1'b0, 26'h0,       1'b0, 32'h0);
    vecs[11] = mk(2'd0, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 32'h0,         1'b0, 26'h0,       1'b1, 32'hFFFF_FFFF);
    vecs[12] = mk(2'd0, 6'h00, 5'd0,  5'd9,  5'd8,  5'd4,  6'h00, 32'hFFFF_0000, 1'b0, 26'h3FF_FFFF, 1'b1, 32'h0009_4100);
    vecs[13] = mk(2'd2, 6'h03, 5'd7,  5'd7,  5'd7,  5'd7,  6'h07, 32'h0,         1'b0, 26'h3FF_FFFF, 1'b1, 32'h0FFF_FFFF);
    vecs[14] = mk(2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 32'h1234_5678, 1'b0, 26'h1234,    1'b1, 32'h0800_1234);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(vecs[0]);
    q.delete(); m_last = '0; m_err = 1'b0; m_errc = 0; m_wc = '0;
    tick(acc);
    tick(acc);
    reset = 1'b0;
    tick(acc);

    // Directed vector table: each request goes in alone and is then drained.
    n_ok = 0; n_bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      set_fields(v);
      in_valid = 1'b1;
      tick(acc);
      in_valid = 1'b0;
      if (v.ok) begin
        n_ok++;
        chk($sformatf("vec%0d word", i), out_instr, v.word);
        chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      end else begin
        n_bad++;
        chk($sformatf("vec%0d err_pulse", i), 32'(err_pulse), 32'd1);
        chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd0);
      end
      chk($sformatf("vec%0d word_count", i), 32'(word_count), 32'(n_ok));
      chk($sformatf("vec%0d err_count", i), 32'(err_count), 32'(n_bad));
      tick(acc);
      chk($sformatf("vec%0d pulse cleared", i), 32'(err_pulse), 32'd0);
    end

    // Fill to full with the consumer stalled; the fifth request must wait for a pop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_j(26'h100 + 26'(k));
      tick(acc);
    end
    chk("full in_ready", 32'(in_ready), 32'd0);
    set_j(26'h104);
    for (int c = 0; c < 3; c++) tick(acc);
    chk("full held head", out_instr, 32'h0800_0100);
    out_ready = 1'b1;
    done5 = 1'b0;
    got.delete();
    for (int c = 0; c < 12; c++) begin
      if (out_valid) got.push_back(out_instr);
      in_valid = !done5;
      tick(acc);
      if (acc) done5 = 1'b1;
    end
    in_valid = 1'b0;
    chk("fifth accepted", 32'(done5), 32'd1);
    chk("drained count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("drain order %0d", k), got[k], 32'h0800_0100 + 32'(k));

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_fields();
      tick(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick(acc);
    chk("random drained", 32'(out_valid), 32'd0);

    // Steady push+pop at occupancy 2.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_j(26'h200); tick(acc);
    set_j(26'h201); tick(acc);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_j(26'h202 + 26'(c));
      tick(acc);
      chk("steady occupancy", 32'(dut.w_occupancy), 32'd2);
    end
    in_valid = 1'b0;
    tick(acc);
    tick(acc);

    // Error counter saturation.
    in_valid  = 1'b1;
    in_format = 2'd3;
    for (int c = 0; c < 300; c++) tick(acc);
    chk("err_count saturated", 32'(err_count), 32'hFF);
    in_valid = 1'b0;
    tick(acc);

    // Reset with words queued and a request pending in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_j(26'h300 + 26'(k));
      tick(acc);
    end
    reset = 1'b1;
    tick(acc);
    reset = 1'b0;
    in_valid = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_instr", out_instr, 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset word_count", 32'(word_count), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    v = mk(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0085_3022);
    set_fields(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    chk("post-reset word", out_instr, v.word);
    chk("post-reset word_count", 32'(word_count), 32'd1);
    tick(acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
